// File: rtl/core_bus_arbiter.sv
// core_bus_arbiter: round-robin arbiter merging core I/D requests onto one single-beat memory bus
// ports: clk, reset (async active-low), ireq/iresp (instruction master), dreq/dresp (data master),
//        creq/cresp (memory bus); creq is driven only from registered state
package core_bus_pkg;
  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
  } ibus_req_t;
  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;
  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;
  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;
  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [2:0]  size;
    logic [63:0] addr;
    logic [7:0]  strobe;
    logic [63:0] data;
  } cbus_req_t;
  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
  } cbus_resp_t;
endpackage

module core_bus_arbiter
  import core_bus_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  ibus_req_t  ireq,
  output ibus_resp_t iresp,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp,
  output cbus_req_t  creq,
  input  cbus_resp_t cresp
);
  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;
  state_t      state;
  logic        last_grant;
  logic [63:0] lat_addr;
  logic [63:0] lat_data;
  logic [2:0]  lat_size;
  logic [7:0]  lat_strobe;
  logic        busy;
  logic        done;
  logic        grant_d;
  assign busy = state != IDLE;
  assign done = busy & cresp.ready & cresp.last;
  // last_grant: 0 = I, 1 = D; on a tie the master that did not win last time goes next
  assign grant_d = dreq.valid & (~ireq.valid | ~last_grant);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      last_grant <= 1'b0;
      lat_addr   <= '0;
      lat_data   <= '0;
      lat_size   <= '0;
      lat_strobe <= '0;
    end else if (state == IDLE) begin
      if (grant_d) begin
        state      <= BUSY_D;
        last_grant <= 1'b1;
        lat_addr   <= dreq.addr;
        lat_data   <= dreq.data;
        lat_size   <= dreq.size;
        lat_strobe <= dreq.strobe;
      end else if (ireq.valid) begin
        state      <= BUSY_I;
        last_grant <= 1'b0;
        lat_addr   <= ireq.addr;
        lat_data   <= '0;
        lat_size   <= 3'b010;
        lat_strobe <= '0;
      end
    end else if (done) begin
      state <= IDLE;
    end
  end
  // instruction fetches latch a zero strobe, so is_write needs no state qualification
  assign creq = busy ? cbus_req_t'{valid: 1'b1, is_write: |lat_strobe, size: lat_size,
                                   addr: lat_addr, strobe: lat_strobe, data: lat_data} : '0;
  assign iresp = ibus_resp_t'{addr_ok: done & (state == BUSY_I), data_ok: done & (state == BUSY_I),
                              data: lat_addr[2] ? cresp.data[63:32] : cresp.data[31:0]};
  assign dresp = dbus_resp_t'{addr_ok: done & (state == BUSY_D), data_ok: done & (state == BUSY_D),
                              data: cresp.data};
endmodule

// File: tb/tb_core_bus_arbiter.sv
// tb_core_bus_arbiter: vector table, directed corner sequences and randomized model comparison
module tb_core_bus_arbiter;
  import core_bus_pkg::*;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  ibus_req_t  ireq;
  ibus_resp_t iresp;
  dbus_req_t  dreq;
  dbus_resp_t dresp;
  cbus_req_t  creq;
  cbus_resp_t cresp;
  int checks = 0;
  int failures = 0;
  int m_owner = 0;
  logic m_last_d = 1'b0;
  cbus_req_t m_req = '0;

  core_bus_arbiter dut (
    .clk(clk), .reset(reset), .ireq(ireq), .iresp(iresp),
    .dreq(dreq), .dresp(dresp), .creq(creq), .cresp(cresp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [63:0] ia;
    logic        dv;
    logic [63:0] da;
    logic [7:0]  ds;
    logic        rdy;
    logic        lst;
    logic [63:0] cd;
    logic        cv;
    logic        cw;
    logic [63:0] ca;
    logic [2:0]  csz;
    logic        iok;
    logic        dok;
    logic [63:0] ed;
  } vec_t;
  vec_t tbl[12];

  localparam logic [63:0] IA  = 64'h0000_0000_8000_0004;
  localparam logic [63:0] CD1 = 64'h1122_3344_5566_7788;
  localparam logic [63:0] CD2 = 64'hAABB_CCDD_EEFF_0011;

  function automatic void chk(string nm, logic [63:0] a, logic [63:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, a, e);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(logic iv, logic [63:0] ia, logic dv, logic [63:0] da, logic [7:0] ds,
                       logic rdy, logic lst, logic [63:0] cd);
    ireq  = '{valid: iv, addr: ia};
    dreq  = '{valid: dv, addr: da, size: 3'b011, strobe: ds, data: 64'hDEAD_BEEF_0BAD_F00D};
    cresp = '{ready: rdy, last: lst, data: cd};
  endtask

  task automatic cyc();
    cbus_req_t e;
    logic done;
    logic pick_d;
    #1;
    if (!reset) begin
      m_owner  = 0;
      m_last_d = 1'b0;
    end
    e = '0;
    if (m_owner != 0) e = m_req;
    chk("rnd_creq_valid", creq.valid, e.valid);
    chk("rnd_creq_is_write", creq.is_write, e.is_write);
    chk("rnd_creq_size", creq.size, e.size);
    chk("rnd_creq_addr", creq.addr, e.addr);
    chk("rnd_creq_strobe", creq.strobe, e.strobe);
    chk("rnd_creq_data", creq.data, e.data);
    done = cresp.ready && cresp.last && m_owner != 0;
    chk("rnd_i_ok", {iresp.addr_ok, iresp.data_ok}, {2{done && m_owner == 1}});
    chk("rnd_d_ok", {dresp.addr_ok, dresp.data_ok}, {2{done && m_owner == 2}});
    if (done && m_owner == 1)
      chk("rnd_idata", iresp.data, m_req.addr[2] ? cresp.data[63:32] : cresp.data[31:0]);
    if (done && m_owner == 2) chk("rnd_ddata", dresp.data, cresp.data);
    @(posedge clk);
    if (reset) begin
      if (done) m_owner = 0;
      else if (m_owner == 0 && (ireq.valid || dreq.valid)) begin
        pick_d = (ireq.valid && dreq.valid) ? !m_last_d : dreq.valid;
        m_last_d = pick_d;
        m_owner  = pick_d ? 2 : 1;
        m_req = pick_d ? cbus_req_t'{1'b1, |dreq.strobe, dreq.size, dreq.addr, dreq.strobe, dreq.data}
                       : cbus_req_t'{1'b1, 1'b0, 3'b010, ireq.addr, 8'h00, 64'h0};
      end
    end
    @(negedge clk);
  endtask

  initial begin
    tbl[0]  = '{1'b1, IA, 1'b0, 64'h0, 8'h00, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 3'd0, 1'b0, 1'b0, 64'h0};
    tbl[1]  = '{1'b1, IA, 1'b0, 64'h0, 8'h00, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0, IA, 3'd2, 1'b0, 1'b0, 64'h0};
    tbl[2]  = '{1'b1, IA, 1'b0, 64'h0, 8'h00, 1'b1, 1'b0, CD1, 1'b1, 1'b0, IA, 3'd2, 1'b0, 1'b0, 64'h0};
    tbl[3]  = '{1'b0, 64'h0, 1'b0, 64'h0, 8'h00, 1'b1, 1'b1, CD1, 1'b1, 1'b0, IA, 3'd2, 1'b1, 1'b0, 64'h1122_3344};
    tbl[4]  = '{1'b0, 64'h0, 1'b0, 64'h0, 8'h00, 1'b1, 1'b1, CD1, 1'b0, 1'b0, 64'h0, 3'd0, 1'b0, 1'b0, 64'h0};
    tbl[5]  = '{1'b1, 64'h1000, 1'b1, 64'h100, 8'h0F, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 3'd0, 1'b0, 1'b0, 64'h0};
    tbl[6]  = '{1'b1, 64'h1000, 1'b1, 64'h200, 8'h0F, 1'b0, 1'b0, 64'h0, 1'b1, 1'b1, 64'h100, 3'd3, 1'b0, 1'b0, 64'h0};
    tbl[7]  = '{1'b1, 64'h1000, 1'b1, 64'h200, 8'h0F, 1'b1, 1'b1, CD2, 1'b1, 1'b1, 64'h100, 3'd3, 1'b0, 1'b1, CD2};
    tbl[8]  = '{1'b1, 64'h1000, 1'b1, 64'h200, 8'h00, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 3'd0, 1'b0, 1'b0, 64'h0};
    tbl[9]  = '{1'b1, 64'h1000, 1'b1, 64'h200, 8'h00, 1'b1, 1'b1, CD2, 1'b1, 1'b0, 64'h1000, 3'd2, 1'b1, 1'b0, 64'hEEFF_0011};
    tbl[10] = '{1'b1, 64'h1000, 1'b1, 64'h200, 8'h00, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 3'd0, 1'b0, 1'b0, 64'h0};
    tbl[11] = '{1'b0, 64'h0, 1'b0, 64'h0, 8'h00, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 64'h200, 3'd3, 1'b0, 1'b0, 64'h0};
    drive(1'b1, IA, 1'b1, 64'h100, 8'hFF, 1'b1, 1'b1, CD1);
    @(negedge clk);
    #1;
    chk("reset_creq", creq, '0);
    chk("reset_oks", {iresp.addr_ok, iresp.data_ok, dresp.addr_ok, dresp.data_ok}, 4'b0);
    tick();
    reset = 1'b1;
    foreach (tbl[k]) begin
      drive(tbl[k].iv, tbl[k].ia, tbl[k].dv, tbl[k].da, tbl[k].ds, tbl[k].rdy, tbl[k].lst, tbl[k].cd);
      #1;
      chk($sformatf("vec%0d_valid", k), creq.valid, tbl[k].cv);
      chk($sformatf("vec%0d_is_write", k), creq.is_write, tbl[k].cw);
      chk($sformatf("vec%0d_addr", k), creq.addr, tbl[k].ca);
      chk($sformatf("vec%0d_size", k), creq.size, tbl[k].csz);
      chk($sformatf("vec%0d_i_ok", k), {iresp.addr_ok, iresp.data_ok}, {2{tbl[k].iok}});
      chk($sformatf("vec%0d_d_ok", k), {dresp.addr_ok, dresp.data_ok}, {2{tbl[k].dok}});
      if (tbl[k].iok) chk($sformatf("vec%0d_idata", k), iresp.data, tbl[k].ed);
      if (tbl[k].dok) chk($sformatf("vec%0d_ddata", k), dresp.data, tbl[k].ed);
      tick();
    end
    for (int c = 0; c < 4; c++) begin
      drive(1'b0, 64'h0, 1'b0, 64'h0, 8'h00, 1'b1, c == 2 || c == 3, CD1);
      #1;
      chk($sformatf("partial%0d_valid", c), creq.valid, c < 3);
      chk($sformatf("partial%0d_d_ok", c), dresp.data_ok, c == 2);
      tick();
    end
    drive(1'b1, 64'h40, 1'b0, 64'h0, 8'h00, 1'b0, 1'b0, 64'h0);
    tick();
    #1;
    chk("pre_abort_addr", creq.addr, 64'h40);
    drive(1'b1, 64'h40, 1'b0, 64'h0, 8'h00, 1'b1, 1'b1, CD1);
    reset = 1'b0;
    #1;
    chk("abort_valid", creq.valid, 1'b0);
    chk("abort_addr", creq.addr, 64'h0);
    chk("abort_i_ok", iresp.data_ok, 1'b0);
    tick();
    reset = 1'b1;
    for (int c = 0; c < 12; c++) begin
      drive(1'b1, 64'h2000, 1'b1, 64'h3000, 8'h01, 1'b1, 1'b1, CD2);
      #1;
      chk($sformatf("rr%0d_valid", c), creq.valid, c % 2 == 1);
      chk($sformatf("rr%0d_d_ok", c), dresp.data_ok, c % 4 == 1);
      chk($sformatf("rr%0d_i_ok", c), iresp.data_ok, c % 4 == 3);
      tick();
    end
    reset = 1'b0;
    drive(1'b0, 64'h0, 1'b0, 64'h0, 8'h00, 1'b0, 1'b0, 64'h0);
    cyc();
    reset = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      reset = $urandom_range(63) != 0;
      drive($urandom_range(1) != 0, {$urandom, $urandom}, $urandom_range(1) != 0, {$urandom, $urandom},
            ($urandom_range(3) == 0) ? 8'h00 : 8'($urandom), $urandom_range(1) != 0,
            $urandom_range(1) != 0, {$urandom, $urandom});
      dreq.size = 3'($urandom);
      dreq.data = {$urandom, $urandom};
      cyc();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
